// File: rtl/rst_seq_gen.sv
// rst_seq_gen: staged reset sequencer driven by a filtered PLL lock.
// lock_i is synchronised and filtered for glitches. Once lock is stable, the
// block releases NUM_CH active-low resets in index order, DLY_STEP cycles apart.
// Sticky channels keep their released state when lock is lost.
// sw_rst_i forces a full re-sequence, and it also clears sticky channels.

module rst_seq_gen #(
  parameter int                NUM_CH      = 3,
  parameter int                CNT_W       = 16,
  parameter int                LOCK_FILT   = 8,
  parameter int                DLY_STEP    = 16,
  parameter int                LOSS_FILT   = 4,
  parameter logic [NUM_CH-1:0] STICKY_MASK = 3'b001
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              lock_i,
  input  logic              sw_rst_i,
  output logic [NUM_CH-1:0] rst_n_o,
  output logic              done_o,
  output logic              lock_lost_o,
  output logic [1:0]        state_o
);

  localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  localparam logic [CNT_W-1:0] LOCK_LAST = CNT_W'(LOCK_FILT - 1);
  localparam logic [CNT_W-1:0] STEP_LAST = CNT_W'(DLY_STEP - 1);
  localparam logic [CNT_W-1:0] LOSS_LAST = CNT_W'(LOSS_FILT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_CH - 1);

  typedef enum logic [1:0] {
    ST_WAIT_LOCK = 2'b00,
    ST_FILTER    = 2'b01,
    ST_RELEASE   = 2'b10,
    ST_RUN       = 2'b11
  } state_t;

  // Registered state
  logic              r_sync1;
  logic              r_sync2;
  state_t            r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic [CNT_W-1:0]  r_losscnt;
  logic [IDX_W-1:0]  r_idx;
  logic [NUM_CH-1:0] r_rst_n;
  logic              r_done;
  logic              r_lost;

  // Next-state values
  state_t            w_state_nxt;
  logic [CNT_W-1:0]  w_cnt_nxt;
  logic [CNT_W-1:0]  w_losscnt_nxt;
  logic [IDX_W-1:0]  w_idx_nxt;
  logic [NUM_CH-1:0] w_rst_n_nxt;
  logic              w_done_nxt;
  logic              w_lost_nxt;
  logic              w_loss_evt;
  logic              w_lock_s;

  assign w_lock_s = r_sync2;

  // Two-flop synchroniser that brings the asynchronous lock_i into clk_i
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= lock_i;
      r_sync2 <= r_sync1;
    end
  end

  // State, counter and output registers
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state   <= ST_WAIT_LOCK;
      r_cnt     <= {CNT_W{1'b0}};
      r_losscnt <= {CNT_W{1'b0}};
      r_idx     <= {IDX_W{1'b0}};
      r_rst_n   <= {NUM_CH{1'b0}};
      r_done    <= 1'b0;
      r_lost    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_losscnt <= w_losscnt_nxt;
      r_idx     <= w_idx_nxt;
      r_rst_n   <= w_rst_n_nxt;
      r_done    <= w_done_nxt;
      r_lost    <= w_lost_nxt;
    end
  end

  // Next-state logic: priority is sw_rst_i, then lock loss, then normal sequencing
  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_losscnt_nxt = {CNT_W{1'b0}};
    w_idx_nxt     = r_idx;
    w_rst_n_nxt   = r_rst_n;
    w_done_nxt    = r_done;
    w_lost_nxt    = r_lost;
    w_loss_evt    = 1'b0;

    // Loss is only watched once the channels start to release.
    // The last of LOSS_FILT consecutive low samples raises the loss event.
    if ((r_state == ST_RELEASE) || (r_state == ST_RUN)) begin
      if (!w_lock_s) begin
        if (r_losscnt == LOSS_LAST) begin
          w_loss_evt = 1'b1;
        end else begin
          w_losscnt_nxt = r_losscnt + CNT_W'(1);
        end
      end else begin
        w_losscnt_nxt = {CNT_W{1'b0}};
      end
    end else begin
      w_losscnt_nxt = {CNT_W{1'b0}};
    end

    if (sw_rst_i) begin
      w_state_nxt   = ST_WAIT_LOCK;
      w_cnt_nxt     = {CNT_W{1'b0}};
      w_losscnt_nxt = {CNT_W{1'b0}};
      w_idx_nxt     = {IDX_W{1'b0}};
      w_rst_n_nxt   = {NUM_CH{1'b0}};
      w_done_nxt    = 1'b0;
      w_lost_nxt    = 1'b0;
    end else if (w_loss_evt) begin
      // Loss takes precedence over a release scheduled on the same edge.
      w_state_nxt   = ST_WAIT_LOCK;
      w_cnt_nxt     = {CNT_W{1'b0}};
      w_losscnt_nxt = {CNT_W{1'b0}};
      w_idx_nxt     = {IDX_W{1'b0}};
      w_rst_n_nxt   = r_rst_n & STICKY_MASK;
      w_done_nxt    = 1'b0;
      w_lost_nxt    = 1'b1;
    end else begin
      case (r_state)
        ST_WAIT_LOCK: begin
          if (w_lock_s) begin
            w_state_nxt = ST_FILTER;
            w_cnt_nxt   = {CNT_W{1'b0}};
          end else begin
            w_state_nxt = ST_WAIT_LOCK;
          end
        end
        ST_FILTER: begin
          if (!w_lock_s) begin
            w_state_nxt = ST_WAIT_LOCK;
            w_cnt_nxt   = {CNT_W{1'b0}};
          end else if (r_cnt == LOCK_LAST) begin
            w_state_nxt = ST_RELEASE;
            w_cnt_nxt   = {CNT_W{1'b0}};
            w_idx_nxt   = {IDX_W{1'b0}};
          end else begin
            w_cnt_nxt   = r_cnt + CNT_W'(1);
          end
        end
        ST_RELEASE: begin
          if (r_cnt == STEP_LAST) begin
            // A sticky channel that is already released is simply set again.
            // Its slot still takes the full DLY_STEP delay.
            w_rst_n_nxt[r_idx] = 1'b1;
            w_cnt_nxt          = {CNT_W{1'b0}};
            if (r_idx == IDX_LAST) begin
              w_state_nxt = ST_RUN;
              w_done_nxt  = 1'b1;
            end else begin
              w_idx_nxt   = r_idx + IDX_W'(1);
            end
          end else begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
          end
        end
        ST_RUN: begin
          w_state_nxt = ST_RUN;
        end
        default: begin
          w_state_nxt = ST_WAIT_LOCK;
          w_cnt_nxt   = {CNT_W{1'b0}};
          w_idx_nxt   = {IDX_W{1'b0}};
          w_rst_n_nxt = {NUM_CH{1'b0}};
          w_done_nxt  = 1'b0;
        end
      endcase
    end
  end

  assign rst_n_o     = r_rst_n;
  assign done_o      = r_done;
  assign lock_lost_o = r_lost;
  assign state_o     = r_state;

endmodule

// File: tb/tb_rst_seq_gen.sv
// Testbench for rst_seq_gen.
// Each edge is checked against a timeline model of the sequencer.
// The model tracks the lock-valid time T0 and derives each channel's release
// edge from it.

module tb_rst_seq_gen;

  localparam int             NUM_CH = 3;
  localparam int             LF     = 8;
  localparam int             DS     = 16;
  localparam int             LOSS   = 4;
  localparam logic [2:0]     MASK   = 3'b001;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       lock = 1'b0;
  logic       sw = 1'b0;
  logic [2:0] rst_n_o;
  logic       done_o;
  logic       lock_lost_o;
  logic [1:0] state_o;

  always #5 clk = ~clk;

  rst_seq_gen #(
    .NUM_CH(NUM_CH), .CNT_W(16), .LOCK_FILT(LF), .DLY_STEP(DS),
    .LOSS_FILT(LOSS), .STICKY_MASK(MASK)
  ) dut (
    .clk_i(clk), .rst_i(rst), .lock_i(lock), .sw_rst_i(sw),
    .rst_n_o(rst_n_o), .done_o(done_o), .lock_lost_o(lock_lost_o),
    .state_o(state_o)
  );

  int n_chk = 0;
  int n_pass = 0;
  int edge_n = 0;
  bit lk1, lk2;

  // Model: phase 0 = waiting for lock, 1 = filtering since T0, 2 = releasing/running
  int         m_phase;
  int         m_t0;
  int         m_low;
  logic [2:0] m_rst_n;
  bit         m_done;
  bit         m_lost;

  int         rise [NUM_CH];
  int         done_rise;
  logic [2:0] prev_rst_n;
  logic       prev_done;
  int         t;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s (edge %0d): got %0h expected %0h", tag, edge_n, obs, exp);
  endtask

  task automatic clear_rises();
    for (int k = 0; k < NUM_CH; k++) rise[k] = 0;
    done_rise = 0;
  endtask

  task automatic model_init();
    m_phase = 0; m_t0 = 0; m_low = 0;
    m_rst_n = 3'b000; m_done = 1'b0; m_lost = 1'b0;
    edge_n = 0; lk1 = 1'b0; lk2 = 1'b0;
    prev_rst_n = 3'b000; prev_done = 1'b0;
    clear_rises();
  endtask

  function automatic logic [1:0] exp_state();
    if (m_phase == 0)      return 2'd0;
    else if (m_phase == 1) return 2'd1;
    else if (m_done)       return 2'd3;
    else                   return 2'd2;
  endfunction

  // Model one rising edge n, where s is the synchronised lock value seen at that edge
  task automatic model_edge(input int n, input bit s, input bit swv);
    if (swv) begin
      m_phase = 0; m_low = 0; m_rst_n = 3'b000; m_done = 1'b0; m_lost = 1'b0;
    end else if (m_phase == 0) begin
      if (s) begin m_phase = 1; m_t0 = n; end
    end else if (m_phase == 1) begin
      if (!s) m_phase = 0;
      else if (n == m_t0 + LF) begin m_phase = 2; m_low = 0; end
    end else begin
      m_low = s ? 0 : m_low + 1;
      if (m_low == LOSS) begin
        m_phase = 0; m_low = 0; m_rst_n = m_rst_n & MASK;
        m_done = 1'b0; m_lost = 1'b1;
      end else begin
        for (int k = 0; k < NUM_CH; k++) begin
          if (n == m_t0 + LF + (k + 1) * DS) begin
            m_rst_n[k] = 1'b1;
            if (k == NUM_CH - 1) m_done = 1'b1;
          end
        end
      end
    end
  endtask

  task automatic step();
    bit s, swv;
    s = lk2; swv = sw;
    edge_n++;
    lk2 = lk1; lk1 = lock;
    @(posedge clk);
    model_edge(edge_n, s, swv);
    @(negedge clk);
    chk("rst_n", {29'd0, rst_n_o}, {29'd0, m_rst_n});
    chk("done", {31'd0, done_o}, {31'd0, m_done});
    chk("lock_lost", {31'd0, lock_lost_o}, {31'd0, m_lost});
    chk("state", {30'd0, state_o}, {30'd0, exp_state()});
    for (int k = 0; k < NUM_CH; k++)
      if (rst_n_o[k] === 1'b1 && prev_rst_n[k] === 1'b0 && rise[k] == 0) rise[k] = edge_n;
    if (done_o === 1'b1 && prev_done === 1'b0 && done_rise == 0) done_rise = edge_n;
    prev_rst_n = rst_n_o; prev_done = done_o;
  endtask

  task automatic run(input int cycles);
    repeat (cycles) step();
  endtask

  task automatic do_reset(input bit lk);
    rst = 1'b1; sw = 1'b0; lock = lk;
    @(posedge clk); @(posedge clk); @(negedge clk);
    rst = 1'b0;
    model_init();
  endtask

  initial begin
    lock = 1'b1;
    #1;
    chk("reset_rst_n", {29'd0, rst_n_o}, 32'd0);
    chk("reset_done", {31'd0, done_o}, 32'd0);
    chk("reset_lost", {31'd0, lock_lost_o}, 32'd0);
    chk("reset_state", {30'd0, state_o}, 32'd0);

    // Scenario 1: lock is stable through reset, so T0 is edge 3
    do_reset(1'b1);
    run(65);
    chk("s1_rise0", rise[0], 32'd27);
    chk("s1_rise1", rise[1], 32'd43);
    chk("s1_rise2", rise[2], 32'd59);
    chk("s1_done", done_rise, 32'd59);

    // Scenario 2: a short dropout in RUN is ignored; a long one is lock loss
    lock = 1'b0; run(3);
    lock = 1'b1; run(10);
    chk("s2_short_rst_n", {29'd0, rst_n_o}, 32'h7);
    lock = 1'b0; run(10);
    chk("s2_loss_rst_n", {29'd0, rst_n_o}, 32'h1);
    chk("s2_loss_flag", {31'd0, lock_lost_o}, 32'd1);
    chk("s2_loss_done", {31'd0, done_o}, 32'd0);
    clear_rises();
    lock = 1'b1; t = edge_n;
    run(70);
    // Relock: lock_s rises at t+3, which is the new T0
    chk("s2_sticky_held", rise[0], 32'd0);
    chk("s2_rise1", rise[1], t + 3 + 40);
    chk("s2_rise2", rise[2], t + 3 + 56);

    // Scenario 3: a one-cycle sw_rst_i pulse clears everything, including sticky channels
    sw = 1'b1; step(); sw = 1'b0;
    chk("s3_rst_n", {29'd0, rst_n_o}, 32'd0);
    chk("s3_lost", {31'd0, lock_lost_o}, 32'd0);
    chk("s3_state", {30'd0, state_o}, 32'd0);
    clear_rises(); t = edge_n;
    run(65);
    chk("s3_rise0", rise[0], t + 25);
    chk("s3_rise1", rise[1], t + 41);
    chk("s3_rise2", rise[2], t + 57);

    // Scenario 4: loss declared on the same edge that channel 1 would release
    do_reset(1'b1);
    run(37);
    lock = 1'b0; run(4);
    lock = 1'b1; run(2);
    chk("s4_rst_n", {29'd0, rst_n_o}, 32'h1);
    chk("s4_state", {30'd0, state_o}, 32'd0);
    chk("s4_lost", {31'd0, lock_lost_o}, 32'd1);
    run(70);

    // Scenario 5: asynchronous rst_i while releasing channel 1
    do_reset(1'b1);
    run(35);
    #2 rst = 1'b1;
    #1;
    chk("s5_async_rst_n", {29'd0, rst_n_o}, 32'd0);
    chk("s5_async_state", {30'd0, state_o}, 32'd0);
    chk("s5_async_done", {31'd0, done_o}, 32'd0);
    do_reset(1'b1);
    run(65);
    chk("s5_rise0", rise[0], 32'd27);
    chk("s5_rise1", rise[1], 32'd43);
    chk("s5_rise2", rise[2], 32'd59);

    // Scenario 6: a glitchy lock restarts FILTER each time it drops
    do_reset(1'b0);
    run(5);
    repeat (6) begin
      lock = 1'b1; run(4);
      lock = 1'b0; run(1);
    end
    clear_rises(); t = edge_n;
    lock = 1'b1;
    run(70);
    chk("s6_rise0", rise[0], t + 3 + 24);
    chk("s6_rise2", rise[2], t + 3 + 56);

    // Scenario 7: random lock and sw_rst_i activity, checked edge by edge against the model
    do_reset(1'b1);
    for (int seg = 0; seg < 40; seg++) begin
      int kind;
      kind = $urandom_range(0, 9);
      if (kind == 0) begin
        sw = 1'b1; run($urandom_range(1, 3)); sw = 1'b0;
      end else if (kind <= 3) begin
        lock = 1'b0; run($urandom_range(1, 8));
      end else begin
        lock = 1'b1; run($urandom_range(1, 70));
      end
    end
    lock = 1'b1; run(70);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
